// File: rtl/serial_addsub16_if.sv
// Request/result bundle for the bit-serial adder/subtractor.
// The master drives operands and start; the slave returns status and results.
interface serial_addsub16_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             ovf;

  modport master (
    output start, sub, A, B, Cin,
    input  busy, done, Sum, Cout, ovf
  );

  modport slave (
    input  start, sub, A, B, Cin,
    output busy, done, Sum, Cout, ovf
  );
endinterface

// File: rtl/serial_addsub16.sv
// Bit-serial signed adder/subtractor: one full-adder slice and a carry flop,
// LSB first, WIDTH cycles per operation plus a one-cycle DONE.
module serial_addsub16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_addsub16_if.slave   bus
);
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             start_acc;
  logic             last_bit;
  logic             s_bit, c_bit;

  // Subtraction is A + ~B + ~Cin, so inversion happens once at capture.
  assign start_acc = bus.start && (state != RUN);
  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign s_bit     = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_bit     = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Serial datapath; results are loaded only on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.Sum  <= '0;
      bus.Cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else if (start_acc) begin
      a_sh   <= bus.A;
      b_sh   <= bus.sub ? ~bus.B : bus.B;
      carry  <= bus.Cin ^ bus.sub;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh <= {s_bit, res_sh[WIDTH-1:1]};
      carry  <= c_bit;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        bus.Sum  <= {s_bit, res_sh[WIDTH-1:1]};
        bus.Cout <= c_bit;
        bus.ovf  <= carry ^ c_bit;
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub16.sv
// Self-checking bench for serial_addsub16: directed vector table, handshake
// and reset corner sequences, and random operations against an arithmetic model.
module tb_serial_addsub16;
  localparam int unsigned W = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  serial_addsub16_if #(.WIDTH(W)) bus ();

  serial_addsub16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         sb;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ov;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: signed range test for overflow, 17-bit unsigned sum for Cout.
  task automatic model(input logic sb, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, output logic [W-1:0] s, output logic co,
                       output logic ov);
    int ia, ib, ic, tv;
    logic [W:0] u;
    ia = int'($signed(a));
    ib = int'($signed(b));
    ic = cin ? 1 : 0;
    tv = sb ? (ia - ib - ic) : (ia + ib + ic);
    u  = sb ? ({1'b0, a} + {1'b0, ~b} + (W+1)'(1 - ic))
            : ({1'b0, a} + {1'b0, b} + (W+1)'(ic));
    s  = u[W-1:0];
    co = u[W];
    ov = (tv > 32767) || (tv < -32768);
    if (W'(tv) != s) begin
      n_errors++;
      $display("FAIL model_self: wrap 0x%0h vs sum 0x%0h", W'(tv), s);
    end
  endtask

  task automatic launch(input logic sb, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
    bus.sub   = sb;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    bus.Cin   = 1'($urandom);
    bus.sub   = 1'($urandom);
  endtask

  // lat: cycle number in which done is seen (start edge = cycle 0 boundary).
  task automatic wait_done(input string name, output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (!bus.done && lat < 60) begin
      if (bus.busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: done not seen after %0d cycles, required 17", name, lat);
    end
  endtask

  task automatic check_result(input string name, input logic [W-1:0] s, input logic co,
                              input logic ov);
    chk({name, "_sum"},  32'(bus.Sum),  32'(s));
    chk({name, "_cout"}, 32'(bus.Cout), 32'(co));
    chk({name, "_ovf"},  32'(bus.ovf),  32'(ov));
  endtask

  initial begin
    int lat, bcnt;
    logic [W-1:0] ms;
    logic mco, mov;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{"add_0_0",       1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{"add_127_127",   1'b0, 16'h007F, 16'h007F, 1'b0, 16'h00FE, 1'b0, 1'b0};
    vecs[2]  = '{"add_m128_m128", 1'b0, 16'hFF80, 16'hFF80, 1'b0, 16'hFF00, 1'b1, 1'b0};
    vecs[3]  = '{"add_min_max",   1'b0, 16'h8000, 16'h7FFF, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[4]  = '{"add_m1_m1",     1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    vecs[5]  = '{"add_m2_m3",     1'b0, 16'hFFFE, 16'hFFFD, 1'b0, 16'hFFFB, 1'b1, 1'b0};
    vecs[6]  = '{"add_ovf_pos",   1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[7]  = '{"add_ovf_neg",   1'b0, 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[8]  = '{"sub_5_3",       1'b1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0};
    vecs[9]  = '{"sub_3_5_b1",    1'b1, 16'h0003, 16'h0005, 1'b1, 16'hFFFD, 1'b0, 1'b0};
    vecs[10] = '{"sub_min_1",     1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[11] = '{"add_cin_wrap",  1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[12] = '{"add_2_3_c1",    1'b0, 16'h0002, 16'h0003, 1'b1, 16'h0006, 1'b0, 1'b0};

    bus.start = 1'b0; bus.sub = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    check_result("rst", '0, 1'b0, 1'b0);

    // Directed table, including latency and busy-width checks.
    for (int i = 0; i < 13; i++) begin
      launch(vecs[i].sb, vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(vecs[i].name, lat, bcnt);
      chk({vecs[i].name, "_latency"}, 32'(lat), 17);
      chk({vecs[i].name, "_busy_cycles"}, 32'(bcnt), 16);
      check_result(vecs[i].name, vecs[i].sum, vecs[i].cout, vecs[i].ov);
      @(posedge clk); #1;
      chk({vecs[i].name, "_done_pulse"}, 32'(bus.done), 0);
      check_result({vecs[i].name, "_hold"}, vecs[i].sum, vecs[i].cout, vecs[i].ov);
    end

    // Start during RUN is ignored.
    launch(1'b0, 16'd2, 16'd3, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    bus.sub = 1'b0; bus.A = 16'd100; bus.B = 16'd100; bus.Cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("ignore", lat, bcnt);
    chk("ignore_latency", 32'(lat), 12);
    check_result("ignore", 16'd5, 1'b0, 1'b0);

    // Start held in DONE launches the next op without an IDLE cycle.
    bus.sub = 1'b0; bus.A = 16'd7; bus.B = 16'd8; bus.Cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 1);
    chk("b2b_hold_sum", 32'(bus.Sum), 5);
    wait_done("b2b", lat, bcnt);
    chk("b2b_latency", 32'(lat), 17);
    check_result("b2b", 16'd15, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset mid-operation aborts with no done.
    launch(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    repeat (7) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_done", 32'(bus.done), 0);
    check_result("midrst", '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    bcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) bcnt++;
    end
    chk("midrst_no_resume", 32'(bcnt), 0);
    launch(1'b0, 16'd2, 16'd3, 1'b0);
    wait_done("after_rst", lat, bcnt);
    chk("after_rst_latency", 32'(lat), 17);
    check_result("after_rst", 16'd5, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (i % 8 == 0) ra = 16'h8000;
      if (i % 8 == 1) rb = 16'h7FFF;
      model(rs, ra, rb, rc, ms, mco, mov);
      launch(rs, ra, rb, rc);
      wait_done("rand", lat, bcnt);
      check_result($sformatf("rand%0d", i), ms, mco, mov);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/serial_addsub16.md
Name: serial_addsub16

Overview:
- Bit-serial, multi-cycle signed adder/subtractor. Processes one bit per clock, LSB first, using a single full-adder slice and a carry flip-flop.
- It is the area-minimal sequential counterpart to the combinational 16-bit ripple-carry adder. It must produce bit-identical Sum/Cout for the same add operands.
- Adds a subtract mode, a start/busy/done handshake and a signed-overflow flag.
- Used where adder area matters more than latency. Results are cross-checked against the combinational adder in system benches.

Parameters:
WIDTH, 16, operand/result width in bits (>= 2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled when not busy
sub  input  1  0: Sum = A + B + Cin; 1: Sum = A - B - Cin (Cin acts as borrow-in)
A  input  WIDTH  signed operand, sampled with start
B  input  WIDTH  signed operand, sampled with start
Cin  input  1  carry/borrow-in, sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when results update
Sum  output  WIDTH  signed result, held until the next done
Cout  output  1  carry-out of the MSB (sub mode: 1 = no borrow)
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, Sum=0, Cout=0, ovf=0; internal operand registers, bit counter and carry cleared. Reset asserted mid-operation aborts it silently: no done, outputs zero.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1, at the edge:
  - latch a_sh=A and b_sh = sub ? ~B : B
  - carry = sub ? ~Cin : Cin
  - bit counter=0, sub latched, go RUN
- DONE with start=0: go IDLE.
- start in RUN is ignored. A, B, Cin and sub may change freely after capture.
- RUN, each edge:
  - s = a_sh[0]^b_sh[0]^carry
  - carry <= majority(a_sh[0], b_sh[0], carry)
  - a_sh, b_sh shift right by one
  - s shifts into the MSB of the result shift register
  - counter increments
- On the edge processing bit WIDTH-1:
  - record carry-in to the MSB as c_msb
  - go DONE
  - load Sum=result, Cout=final carry, ovf=c_msb^final carry
- busy = (state==RUN), combinational from state.
- done = (state==DONE), exactly one cycle per accepted start.
- Latency: start sampled at edge 0 → busy high for cycles 1..WIDTH → done high in cycle WIDTH+1, with Sum/Cout/ovf valid from that cycle. Throughput: one op per WIDTH+1 cycles. Back-to-back: start held during DONE begins the next op with no IDLE cycle.
- Sum/Cout/ovf change only on entry to DONE; partial results are never visible.
- Arithmetic is modulo 2^WIDTH. Sum equals the low WIDTH bits of A+B+Cin (add) or A+~B+~Cin (sub). Cout is bit WIDTH of the same unsigned sum.
- Counter width: clog2(WIDTH). Wrap is not reachable because the transition at WIDTH-1 is forced.

Test Plan:
- Reset, then add A=2, B=3, Cin=0 → after 17 cycles: done pulse, Sum=5, Cout=0, ovf=0; busy high exactly 16 cycles.
- Add sequence A/B = 0/0, 127/127, -128/-128, -32768/32767, -1/-1, -2/-3 (Cin=0) → Sum = 0, 254, -256, -1, -2, -5. Cout = 0, 0, 1, 0, 1, 1. ovf=0 for all. Each result matches the combinational adder for the same operands.
- Overflow: add 32767+1 → Sum=-32768, ovf=1, Cout=0. Add -32768+(-1) → Sum=32767, ovf=1, Cout=1.
- Subtract: A=5, B=3, Cin=0 → Sum=2, Cout=1. A=3, B=5, Cin=1 → Sum=-3, Cout=0. A=-32768, B=1, Cin=0 → Sum=32767, ovf=1.
- Handshake: pulse start with 2+3, re-pulse start with 100+100 at cycle 5 → second request ignored; single done with Sum=5. Then hold start high through DONE with new operands 7+8 → next op begins immediately; Sum=15 after a further 17 cycles.
- Reset mid-op: start -1+(-1), assert rst_n=0 at cycle 8 → busy/done/Sum/Cout/ovf go 0 immediately, no done pulse. After release, 2+3 completes normally with Sum=5.
